// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The top module and the IF/ID pipeline register both import this package.
package if_stage_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // An all-zero instruction word, used for bubbles and squashed fetches
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Byte distance between consecutive sequential fetches
    localparam int unsigned PC_INC = 4;

    typedef enum logic {
        StHold  = 1'b0,
        StFetch = 1'b1
    } fetch_state_e;

    // Instruction addresses must be word aligned
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction presented to decode.
// A bubble takes priority over stall so that redirects and flushes always squash.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    input  logic              addr_err,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_addr_err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc       <= '0;
            id_inst     <= '0;
            id_valid    <= 1'b0;
            id_addr_err <= 1'b0;
        end else if (bubble) begin
            // Bubble still records the PC that was in IF
            id_pc       <= pc;
            id_inst     <= DATA_W'(NOP);
            id_valid    <= 1'b0;
            id_addr_err <= 1'b0;
        end else if (!stall) begin
            id_pc       <= pc;
            id_inst     <= inst;
            id_valid    <= 1'b1;
            id_addr_err <= addr_err;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, HOLD/FETCH sequencing and ROM interface.
// The ROM is combinational, so the fetched word is captured in IF/ID at the next edge.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              rom_enable,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic              id_addr_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetching;
    logic              bubble;
    logic              misaligned;
    logic [DATA_W-1:0] fetch_inst;

    assign fetching = (state_q == StFetch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHold;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHold:  state_d = StFetch;
            StFetch: state_d = StFetch;
            default: state_d = StHold;
        endcase
    end

    // Priority: flush > redirect > stall > sequential; the add wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (!fetching) begin
            pc_d = RESET_PC;
        end else if (flush) begin
            pc_d = flush_pc;
        end else if (redirect) begin
            pc_d = redirect_pc;
        end else if (!stall) begin
            pc_d = pc_q + ADDR_W'(PC_INC);
        end
    end

    assign rom_enable   = fetching;
    assign rom_addr_out = pc_q;

    // A misaligned fetch is passed on as a valid NOP tagged with the error
    assign misaligned = is_misaligned(pc_q[1:0]);
    assign fetch_inst = misaligned ? DATA_W'(NOP) : rom_data_in;

    // No delay slots: whatever sits in IF during a redirect or flush is squashed
    assign bubble = !fetching || flush || redirect;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .bubble      (bubble),
        .pc          (pc_q),
        .inst        (fetch_inst),
        .addr_err    (misaligned),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .id_addr_err (id_addr_err)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic
// compared against a cycle-level behavioural model of the fetch stage.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, redirect, flush;
    logic [31:0] redirect_pc, flush_pc;
    logic        rom_enable;
    logic [31:0] rom_addr_out, rom_data_in;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, id_addr_err;
    logic [31:0] rom_xor;

    // Narrow instance used for the address wrap check
    logic        stall8, redirect8, flush8;
    logic [7:0]  redirect_pc8, flush_pc8;
    logic        rom_enable8;
    logic [7:0]  rom_addr8, id_pc8;
    logic [31:0] rom_data8, id_inst8;
    logic        id_valid8, id_addr_err8;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_fetch;
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    bit          m_id_valid, m_id_err;

    assign rom_data_in = rom_addr_out ^ rom_xor;
    assign rom_data8   = {24'h0, rom_addr8};

    if_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .rom_enable   (rom_enable),
        .rom_addr_out (rom_addr_out),
        .rom_data_in  (rom_data_in),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .id_addr_err  (id_addr_err)
    );

    if_stage #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (8'h0)
    ) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall8),
        .redirect     (redirect8),
        .redirect_pc  (redirect_pc8),
        .flush        (flush8),
        .flush_pc     (flush_pc8),
        .rom_enable   (rom_enable8),
        .rom_addr_out (rom_addr8),
        .rom_data_in  (rom_data8),
        .id_pc        (id_pc8),
        .id_inst      (id_inst8),
        .id_valid     (id_valid8),
        .id_addr_err  (id_addr_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch    = 1'b0;
        m_pc       = 32'h0;
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_valid = 1'b0;
        m_id_err   = 1'b0;
    endtask

    // What the stage should hold after the coming clock edge, from current inputs
    task automatic model_edge();
        logic [31:0] cur;
        cur = m_pc;
        if (!m_fetch) begin
            m_id_pc = cur; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_err = 1'b0;
            m_pc    = 32'h0;
            m_fetch = 1'b1;
        end else if (flush || redirect) begin
            m_id_pc = cur; m_id_inst = 32'h0; m_id_valid = 1'b0; m_id_err = 1'b0;
            m_pc    = flush ? flush_pc : redirect_pc;
        end else if (!stall) begin
            m_id_pc    = cur;
            m_id_err   = (cur % 4) != 0;
            m_id_inst  = m_id_err ? 32'h0 : (cur ^ rom_xor);
            m_id_valid = 1'b1;
            m_pc       = cur + 32'd4;
        end
    endtask

    task automatic check_model();
        chk("rom_enable", {31'h0, rom_enable}, {31'h0, m_fetch});
        chk("rom_addr", rom_addr_out, m_pc);
        chk("id_pc", id_pc, m_id_pc);
        chk("id_inst", id_inst, m_id_inst);
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_id_valid});
        chk("id_addr_err", {31'h0, id_addr_err}, {31'h0, m_id_err});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic clear_ctl();
        stall = 1'b0; redirect = 1'b0; flush = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        chk({tag, "_en"}, {31'h0, rom_enable}, 32'h0);
        chk({tag, "_addr"}, rom_addr_out, 32'h0);
        chk({tag, "_idpc"}, id_pc, 32'h0);
        chk({tag, "_inst"}, id_inst, 32'h0);
        chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_err"}, {31'h0, id_addr_err}, 32'h0);
        chk({tag, "_en8"}, {31'h0, rom_enable8}, 32'h0);
        chk({tag, "_valid8"}, {31'h0, id_valid8}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_ctl();
        redirect_pc = 32'h0; flush_pc = 32'h0; rom_xor = 32'h0;
        stall8 = 1'b0; redirect8 = 1'b0; flush8 = 1'b0;
        redirect_pc8 = 8'h0; flush_pc8 = 8'h0;
        model_reset();
        #2;
        check_all_clear("por");

        // Reset release: one HOLD cycle, then sequential fetch with ROM = address
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_model();
        step();
        chk("r34_en", {31'h0, rom_enable}, 32'h1);
        chk("r34_addr0", rom_addr_out, 32'h0);
        step();
        chk("r34_addr4", rom_addr_out, 32'h4);
        chk("r34_idpc0", id_pc, 32'h0);
        chk("r34_valid", {31'h0, id_valid}, 32'h1);
        step();
        chk("r34_addr8", rom_addr_out, 32'h8);
        chk("r34_inst4", id_inst, 32'h4);

        rom_xor = 32'h5A5A_0000;
        step();
        step();
        chk("r35_pc10", rom_addr_out, 32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r35_hold_addr", rom_addr_out, 32'h10);
            chk("r35_hold_idpc", id_pc, 32'hC);
        end
        stall = 1'b0;
        step();
        chk("r35_pc14", rom_addr_out, 32'h14);

        for (int i = 0; i < 3; i++) step();
        chk("r36_pc20", rom_addr_out, 32'h20);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        chk("r36_addr", rom_addr_out, 32'h100);
        chk("r36_bubble", {31'h0, id_valid}, 32'h0);
        clear_ctl();
        step();
        chk("r36_idpc", id_pc, 32'h100);
        chk("r36_valid", {31'h0, id_valid}, 32'h1);

        flush = 1'b1; flush_pc = 32'h180; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        chk("r37_addr", rom_addr_out, 32'h180);
        chk("r37_valid", {31'h0, id_valid}, 32'h0);
        chk("r37_inst", id_inst, 32'h0);
        clear_ctl();

        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        clear_ctl();
        step();
        chk("r38_idpc", id_pc, 32'h102);
        chk("r38_err", {31'h0, id_addr_err}, 32'h1);
        chk("r38_inst", id_inst, 32'h0);
        chk("r38_valid", {31'h0, id_valid}, 32'h1);
        chk("r38_addr", rom_addr_out, 32'h106);

        // Asynchronous reset in the middle of a stream
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        clear_ctl();
        step();
        chk("r39_pc44", rom_addr_out, 32'h44);
        rst_n = 1'b0;
        #1;
        check_all_clear("r39_async");
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1'b1;
        step();
        chk("r39_restart", rom_addr_out, 32'h0);
        step();
        chk("r39_next", rom_addr_out, 32'h4);

        // Wrap on the 8-bit instance
        redirect8 = 1'b1; redirect_pc8 = 8'hFC;
        step();
        redirect8 = 1'b0;
        chk("wrap_fc", {24'h0, rom_addr8}, 32'hFC);
        step();
        chk("wrap_00", {24'h0, rom_addr8}, 32'h00);
        chk("wrap_idpc", {24'h0, id_pc8}, 32'hFC);
        chk("wrap_inst", id_inst8, 32'hFC);
        chk("wrap_valid", {31'h0, id_valid8}, 32'h1);
        chk("wrap_err", {31'h0, id_addr_err8}, 32'h0);
        step();
        chk("wrap_04", {24'h0, rom_addr8}, 32'h04);

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_model();
                @(posedge clk);
                #1;
                check_model();
                rst_n = 1'b1;
            end else begin
                stall       = ($urandom_range(0, 3) == 0);
                redirect    = ($urandom_range(0, 7) == 0);
                flush       = ($urandom_range(0, 15) == 0);
                redirect_pc = $urandom;
                flush_pc    = $urandom;
                if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
                if ($urandom_range(0, 3) != 0) flush_pc[1:0] = 2'b00;
                rom_xor = $urandom;
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
